matmul_mem_master: RTL

Initiator-side sequencer for the matrix memory. It reads a 3x3 operand matrix A and a 3x3 operand matrix B over the memread/memwrite word interface, then computes C = A·B. It writes the nine result words back to the result region. It sits between the top-level control and the main memory, driving the memory's read/write strobes, address and write data, and consuming its combinational read data.

---
 rtl/matmul_pkg.sv | 30 +++
 rtl/matmul_mac.sv | 30 +++
 rtl/matmul_mem_master.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and index helpers for the 3x3 matrix-multiply memory master.
package matmul_pkg;

  localparam int N          = 3;
  localparam int ELEMS      = N * N;
  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = 4;

  localparam logic [31:0] DEF_A_BASE = 32'h0000_0200;
  localparam logic [31:0] DEF_B_BASE = 32'h0000_0300;
  localparam logic [31:0] DEF_C_BASE = 32'h0000_0100;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    MAC,
    WR,
    DONE
  } state_e;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [1:0]       rc_t;

  // Row-major flat index of element [r][c].
  function automatic idx_t elem_idx(rc_t r, rc_t c);
    return idx_t'(r) * idx_t'(N) + idx_t'(c);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Multiply-accumulate with clear-on-first-term; products and sums wrap modulo 2^DATA_W.
module matmul_mac #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clear,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] acc_next
);

  logic [DATA_W-1:0] acc_q;

  // acc_next is exposed so the caller can register the final sum in the same edge it lands in acc_q.
  always_comb begin
    acc_next = (clear ? '0 : acc_q) + a * b;
  end

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_next;
    end
  end

endmodule

// File: rtl/matmul_mem_master.sv
// Reads A and B (3x3) from memory, computes C = A*B element by element, writes C back.
module matmul_mem_master
  import matmul_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] A_BASE = ADDR_W'(DEF_A_BASE),
  parameter logic [ADDR_W-1:0] B_BASE = ADDR_W'(DEF_B_BASE),
  parameter logic [ADDR_W-1:0] C_BASE = ADDR_W'(DEF_C_BASE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              memread,
  output logic              memwrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);

  state_e            state_q, state_d;
  idx_t              n_q, n_d;
  rc_t               i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DATA_W-1:0] a_buf_q [ELEMS];
  logic [DATA_W-1:0] a_buf_d [ELEMS];
  logic [DATA_W-1:0] b_buf_q [ELEMS];
  logic [DATA_W-1:0] b_buf_d [ELEMS];

  logic              busy_q, busy_d, done_q, done_d;
  logic              memread_q, memread_d, memwrite_q, memwrite_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              mac_en, mac_clear;
  logic [DATA_W-1:0] mac_a, mac_b, acc_next;

  function automatic logic [ADDR_W-1:0] byte_off(idx_t e);
    return ADDR_W'(e) * ADDR_W'(WORD_BYTES);
  endfunction

  matmul_mac #(.DATA_W(DATA_W)) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (mac_en),
    .clear    (mac_clear),
    .a        (mac_a),
    .b        (mac_b),
    .acc_next (acc_next)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    a_buf_d   = a_buf_q;
    b_buf_d   = b_buf_q;
    mac_en    = 1'b0;
    mac_clear = 1'b0;
    mac_a     = a_buf_q[elem_idx(i_q, k_q)];
    mac_b     = b_buf_q[elem_idx(k_q, j_q)];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_A;
          n_d     = '0;
        end
      end
      RD_A: begin
        a_buf_d[n_q] = rdata;
        if (n_q == idx_t'(ELEMS - 1)) begin
          state_d = RD_B;
          n_d     = '0;
        end else begin
          n_d = n_q + 1'b1;
        end
      end
      RD_B: begin
        b_buf_d[n_q] = rdata;
        if (n_q == idx_t'(ELEMS - 1)) begin
          state_d = MAC;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end else begin
          n_d = n_q + 1'b1;
        end
      end
      MAC: begin
        mac_en    = 1'b1;
        mac_clear = (k_q == '0);
        if (k_q == rc_t'(N - 1)) begin
          state_d = WR;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      WR: begin
        state_d = MAC;
        if (j_q == rc_t'(N - 1)) begin
          j_d = '0;
          if (i_q == rc_t'(N - 1)) begin
            state_d = DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    memread_d  = (state_d == RD_A) || (state_d == RD_B);
    memwrite_d = (state_d == WR);
    busy_d     = state_d inside {RD_A, RD_B, MAC, WR};
    done_d     = (state_d == DONE);
    address_d  = '0;
    wdata_d    = '0;
    unique case (state_d)
      RD_A: address_d = A_BASE + byte_off(n_d);
      RD_B: address_d = B_BASE + byte_off(n_d);
      WR: begin
        address_d = C_BASE + byte_off(elem_idx(i_d, j_d));
        wdata_d   = acc_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      address_q  <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
    end
  end

  // NOTE: operand buffers carry no reset; every word is rewritten by RD_A/RD_B before MAC reads it.
  always_ff @(posedge clk) begin
    a_buf_q <= a_buf_d;
    b_buf_q <= b_buf_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign memread  = memread_q;
  assign memwrite = memwrite_q;
  assign address  = address_q;
  assign wdata    = wdata_q;

endmodule
